// File: rtl/apb_seq_pkg.sv
// Shared encodings for the APB command sequencer: command opcodes, FSM states,
// and opcode normalisation.
package apb_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } seq_state_e;

    // The reserved encoding behaves exactly like a plain read.
    function automatic seq_op_e norm_op(input logic [1:0] raw);
        seq_op_e op;
        case (raw)
            2'd0:    op = OP_WRITE;
            2'd2:    op = OP_POLL;
            default: op = OP_READ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/apb_seq_master_if.sv
// Command, APB and response signals of the sequencer bundled as one interface.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface apb_seq_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output cmd_ready,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY,
        output rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  cmd_ready,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY,
        input  rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/apb_seq_fifo.sv
// Show-ahead synchronous command FIFO: the head entry is readable combinationally so the
// sequencer can pop and launch SETUP on the same edge.
module apb_seq_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit: equal means empty, only the wrap bit differing means full.
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/apb_seq_master.sv
// APB master that drains a FIFO of write/read/poll commands onto an APB slave and
// returns one single-cycle response per command.
module apb_seq_master
    import apb_seq_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int POLL_W = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_seq_master_if.master bus,
    output logic             busy,
    output logic [LVL_W-1:0] level
);

    localparam int              CMD_W    = 2 + ADDR_W + 2 * DATA_W;
    localparam logic [POLL_W-1:0] POLL_MAX = {POLL_W{1'b1}};
    localparam logic [POLL_W-1:0] POLL_ONE = 1;

    logic [CMD_W-1:0]  fifo_wr_data;
    logic [CMD_W-1:0]  fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] head_mask;

    seq_state_e        state_q,     state_d;
    seq_op_e           op_q,        op_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [DATA_W-1:0] mask_q,      mask_d;
    logic [POLL_W-1:0] tries_q,     tries_d;
    logic              retry_q,     retry_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;

    logic [DATA_W-1:0] bit_miss;
    logic              poll_match;

    assign fifo_wr_data = {bus.cmd_op, bus.cmd_addr, bus.cmd_data, bus.cmd_mask};
    assign head_op      = fifo_rd_data[CMD_W-1 -: 2];
    assign head_addr    = fifo_rd_data[2*DATA_W +: ADDR_W];
    assign head_data    = fifo_rd_data[DATA_W +: DATA_W];
    assign head_mask    = fifo_rd_data[0 +: DATA_W];

    apb_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .push    (bus.cmd_valid),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Per-bit poll comparison: a bit only counts when its mask bit is set.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_cmp
        assign bit_miss[gi] = mask_q[gi] & (bus.PRDATA[gi] ^ pwdata_q[gi]);
    end
    assign poll_match = ~|bit_miss;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        mask_d      = mask_q;
        tries_d     = tries_q;
        retry_d     = retry_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (retry_q) begin
                    // Re-issue the same poll after its one-cycle gap, without touching the FIFO.
                    retry_d  = 1'b0;
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = norm_op(head_op);
                    paddr_d  = head_addr;
                    pwdata_d = head_data;
                    mask_d   = head_mask;
                    // tries holds the number of the attempt in flight, so it restarts at one.
                    tries_d  = POLL_ONE;
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = (norm_op(head_op) == OP_WRITE);
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    if (op_q == OP_POLL && !poll_match && tries_q < POLL_MAX) begin
                        tries_d = tries_q + POLL_ONE;
                        retry_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = (op_q == OP_WRITE) ? '0 : bus.PRDATA;
                        rsp_err_d   = (op_q == OP_POLL) && !poll_match;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            mask_q      <= '0;
            tries_q     <= '0;
            retry_q     <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            mask_q      <= mask_d;
            tries_q     <= tries_d;
            retry_q     <= retry_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // A pending poll retry sits in IDLE but still counts as outstanding work.
    assign busy = !fifo_empty || (state_q != ST_IDLE) || retry_q;

endmodule

// File: tb/tb_apb_seq_master.sv
// Directed bench for apb_seq_master: a negedge monitor logs APB transfers and responses,
// and one task per scenario compares the logs against hand-computed expectations.
`timescale 1ns/1ps
module tb_apb_seq_master;
    import apb_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_seq_master_if #(.ADDR_W(8), .DATA_W(8)) m_if ();
    apb_seq_master_if #(.ADDR_W(8), .DATA_W(8)) p_if ();
    logic       busy;
    logic [4:0] level;
    logic       p_busy;
    logic [2:0] p_level;

    apb_seq_master #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .POLL_W(8)) dut (
        .PCLK(clk), .PRESETn(rst_n), .bus(m_if), .busy(busy), .level(level));

    apb_seq_master #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .POLL_W(2)) dut_p (
        .PCLK(clk), .PRESETn(rst_n), .bus(p_if), .busy(p_busy), .level(p_level));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       wr;
        logic       gap_ok;
        int         acc;
        logic       stable;
    } xfer_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    xfer_t      xq[$];
    rsp_t       rq[$];
    logic [7:0] rd_q[$];
    xfer_t      cur;
    rsp_t       r_new;
    logic       prev_psel = 1'b0;
    int         acc_w = 0;
    int         stall = 0;
    logic       hold = 1'b0;
    int         idle_rsp_viol = 0;

    // Slave model and monitor for the main instance.
    always @(negedge clk) begin
        if (m_if.PSELx && !m_if.PENABLE) begin
            cur.cyc    = cyc;
            cur.addr   = m_if.PADDR;
            cur.wdata  = m_if.PWDATA;
            cur.wr     = m_if.PWRITE;
            cur.gap_ok = !prev_psel;
            cur.acc    = 0;
            cur.stable = 1'b1;
            cur.rdata  = 8'h00;
            acc_w      = 0;
        end
        if (m_if.PSELx && m_if.PENABLE) begin
            cur.acc = cur.acc + 1;
            if (m_if.PADDR !== cur.addr || m_if.PWDATA !== cur.wdata || m_if.PWRITE !== cur.wr)
                cur.stable = 1'b0;
            m_if.PRDATA = (rd_q.size() > 0) ? rd_q[0] : 8'h5A;
            m_if.PREADY = !hold && (acc_w >= stall);
            acc_w = acc_w + 1;
            if (m_if.PREADY) begin
                cur.rdata = m_if.PRDATA;
                xq.push_back(cur);
                if (!m_if.PWRITE && rd_q.size() > 0) void'(rd_q.pop_front());
            end
        end else begin
            m_if.PREADY = 1'b0;
        end
        if (m_if.rsp_valid) begin
            r_new.cyc  = cyc;
            r_new.data = m_if.rsp_data;
            r_new.err  = m_if.rsp_err;
            rq.push_back(r_new);
        end else if (m_if.rsp_data !== 8'h00 || m_if.rsp_err !== 1'b0) begin
            idle_rsp_viol = idle_rsp_viol + 1;
        end
        prev_psel = m_if.PSELx;
    end

    int         p_setups = 0;
    int         p_rsps = 0;
    logic [7:0] p_last_data = 8'h00;
    logic       p_last_err = 1'b0;
    always @(negedge clk) begin
        if (p_if.PSELx && !p_if.PENABLE) p_setups = p_setups + 1;
        if (p_if.rsp_valid) begin
            p_rsps      = p_rsps + 1;
            p_last_data = p_if.rsp_data;
            p_last_err  = p_if.rsp_err;
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] mask, output int acc_cyc);
        m_if.cmd_valid = 1'b1;
        m_if.cmd_op    = op;
        m_if.cmd_addr  = addr;
        m_if.cmd_data  = data;
        m_if.cmd_mask  = mask;
        @(negedge clk);
        acc_cyc = cyc;
        m_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int low_cyc, output bit ok);
        ok = 1'b0;
        low_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                low_cyc = cyc;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        m_if.cmd_valid = 1'b0; m_if.cmd_op = 2'd0; m_if.cmd_addr = 8'h00;
        m_if.cmd_data = 8'h00; m_if.cmd_mask = 8'h00;
        p_if.cmd_valid = 1'b0; p_if.cmd_op = 2'd0; p_if.cmd_addr = 8'h00;
        p_if.cmd_data = 8'h00; p_if.cmd_mask = 8'h00;
        p_if.PREADY = 1'b1; p_if.PRDATA = 8'h10;
        repeat (3) @(negedge clk);
        vectors++;
        if ({m_if.PSELx, m_if.PENABLE, m_if.PWRITE} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_apb_ctrl: got %b expected 000", {m_if.PSELx, m_if.PENABLE, m_if.PWRITE});
        end
        vectors++;
        if ({m_if.PADDR, m_if.PWDATA} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_addr_data: got %h expected 0000", {m_if.PADDR, m_if.PWDATA});
        end
        vectors++;
        if ({m_if.cmd_ready, m_if.rsp_valid, m_if.rsp_err, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 1000", {m_if.cmd_ready, m_if.rsp_valid, m_if.rsp_err, busy});
        end
        vectors++;
        if ({m_if.rsp_data, level} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_rsp_level: got %h expected 0", {m_if.rsp_data, level});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        int a, low; bit ok;
        xq.delete(); rq.delete();
        push_cmd(OP_WRITE, 8'h01, 8'h04, 8'h00, a);
        wait_idle(low, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_timeout: got busy expected idle"); end
        vectors++;
        if (xq.size() !== 1 || rq.size() !== 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d xfers %0d rsps expected 1 1", xq.size(), rq.size());
        end else begin
            vectors++;
            if ({xq[0].addr, xq[0].wdata, xq[0].wr} !== {8'h01, 8'h04, 1'b1} || xq[0].cyc !== a + 1) begin
                miscompares++;
                $display("FAIL single_setup: got addr %h data %h wr %b cyc %0d expected 01 04 1 cyc %0d",
                         xq[0].addr, xq[0].wdata, xq[0].wr, xq[0].cyc, a + 1);
            end
            vectors++;
            if (rq[0].cyc !== a + 3 || rq[0].data !== 8'h00 || rq[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL single_rsp: got cyc %0d data %h err %b expected cyc %0d data 00 err 0",
                         rq[0].cyc, rq[0].data, rq[0].err, a + 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a, low; bit ok;
        logic [7:0] ea [10];
        logic [7:0] ed [10];
        logic       ew [10];
        logic [7:0] er [10];
        xq.delete(); rq.delete();
        rd_q.push_back(8'h3C);
        ea[0] = 8'h02; ed[0] = 8'h20; ew[0] = 1'b1; er[0] = 8'h00;
        ea[1] = 8'h03; ed[1] = 8'h00; ew[1] = 1'b0; er[1] = 8'h3C;
        for (int i = 2; i < 10; i++) begin
            ea[i] = 8'h04; ed[i] = 8'(i - 1); ew[i] = 1'b1; er[i] = 8'h00;
        end
        for (int i = 0; i < 10; i++) push_cmd(ew[i] ? 2'd0 : 2'd1, ea[i], ed[i], 8'h00, a);
        wait_idle(low, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got busy expected idle"); end
        vectors++;
        if (xq.size() !== 10 || rq.size() !== 10) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d xfers %0d rsps expected 10 10", xq.size(), rq.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if ({xq[i].addr, xq[i].wdata, xq[i].wr, xq[i].gap_ok} !== {ea[i], ed[i], ew[i], 1'b1}) begin
                    miscompares++;
                    $display("FAIL b2b_xfer%0d: got addr %h data %h wr %b gap %b expected %h %h %b 1",
                             i, xq[i].addr, xq[i].wdata, xq[i].wr, xq[i].gap_ok, ea[i], ed[i], ew[i]);
                end
                vectors++;
                if (rq[i].data !== er[i] || rq[i].err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d: got data %h err %b expected %h 0", i, rq[i].data, rq[i].err, er[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (xq[i].cyc - xq[i-1].cyc !== 3) begin
                        miscompares++;
                        $display("FAIL b2b_period%0d: got %0d expected 3", i, xq[i].cyc - xq[i-1].cyc);
                    end
                end
            end
            vectors++;
            if (low !== rq[9].cyc) begin
                miscompares++;
                $display("FAIL b2b_busy_drop: got cycle %0d expected %0d", low, rq[9].cyc);
            end
        end
        vectors++;
        if (idle_rsp_viol !== 0) begin
            miscompares++;
            $display("FAIL rsp_idle_zero: got %0d nonzero idle cycles expected 0", idle_rsp_viol);
        end
    endtask

    task automatic test_wait_states();
        int a, low; bit ok;
        xq.delete(); rq.delete();
        rd_q.push_back(8'hC3);
        stall = 5;
        push_cmd(OP_READ, 8'h03, 8'h77, 8'h00, a);
        wait_idle(low, ok);
        stall = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wait_timeout: got busy expected idle"); end
        vectors++;
        if (xq.size() !== 1 || rq.size() !== 1) begin
            miscompares++;
            $display("FAIL wait_count: got %0d xfers %0d rsps expected 1 1", xq.size(), rq.size());
        end else begin
            vectors++;
            if (xq[0].acc !== 6 || xq[0].stable !== 1'b1 || xq[0].wdata !== 8'h77) begin
                miscompares++;
                $display("FAIL wait_access: got %0d cycles stable %b data %h expected 6 1 77",
                         xq[0].acc, xq[0].stable, xq[0].wdata);
            end
            vectors++;
            if (rq[0].data !== 8'hC3 || rq[0].cyc !== xq[0].cyc + 7) begin
                miscompares++;
                $display("FAIL wait_rsp: got data %h cyc %0d expected C3 cyc %0d", rq[0].data, rq[0].cyc, xq[0].cyc + 7);
            end
        end
    endtask

    task automatic test_poll();
        int a, low; bit ok;
        xq.delete(); rq.delete();
        rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'h81);
        push_cmd(OP_POLL, 8'h03, 8'h80, 8'h80, a);
        wait_idle(low, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL poll_timeout: got busy expected idle"); end
        vectors++;
        if (xq.size() !== 3 || rq.size() !== 1) begin
            miscompares++;
            $display("FAIL poll_count: got %0d xfers %0d rsps expected 3 1", xq.size(), rq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if ({xq[i].addr, xq[i].wr, xq[i].gap_ok} !== {8'h03, 1'b0, 1'b1} || xq[i].cyc !== a + 1 + 3 * i) begin
                    miscompares++;
                    $display("FAIL poll_xfer%0d: got addr %h wr %b gap %b cyc %0d expected 03 0 1 cyc %0d",
                             i, xq[i].addr, xq[i].wr, xq[i].gap_ok, xq[i].cyc, a + 1 + 3 * i);
                end
            end
            vectors++;
            if (rq[0].data !== 8'h81 || rq[0].err !== 1'b0 || rq[0].cyc !== a + 9) begin
                miscompares++;
                $display("FAIL poll_rsp: got data %h err %b cyc %0d expected 81 0 cyc %0d",
                         rq[0].data, rq[0].err, rq[0].cyc, a + 9);
            end
        end
    endtask

    task automatic test_poll_mask0();
        int a, low; bit ok;
        xq.delete(); rq.delete();
        rd_q.push_back(8'h42);
        push_cmd(OP_POLL, 8'h05, 8'hFF, 8'h00, a);
        wait_idle(low, ok);
        vectors++;
        if (xq.size() !== 1 || rq.size() !== 1) begin
            miscompares++;
            $display("FAIL mask0_count: got %0d xfers %0d rsps expected 1 1", xq.size(), rq.size());
        end else begin
            vectors++;
            if (rq[0].data !== 8'h42 || rq[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL mask0_rsp: got data %h err %b expected 42 0", rq[0].data, rq[0].err);
            end
        end
    endtask

    task automatic test_reserved_op();
        int a, low; bit ok;
        xq.delete(); rq.delete();
        rd_q.push_back(8'h99);
        push_cmd(2'd3, 8'h06, 8'h11, 8'hFF, a);
        wait_idle(low, ok);
        vectors++;
        if (xq.size() !== 1 || rq.size() !== 1) begin
            miscompares++;
            $display("FAIL rsvd_count: got %0d xfers %0d rsps expected 1 1", xq.size(), rq.size());
        end else begin
            vectors++;
            if (xq[0].wr !== 1'b0 || rq[0].data !== 8'h99 || rq[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL rsvd_read: got wr %b data %h err %b expected 0 99 0", xq[0].wr, rq[0].data, rq[0].err);
            end
        end
    endtask

    task automatic test_poll_exhaust();
        bit ok;
        p_setups = 0; p_rsps = 0;
        p_if.cmd_valid = 1'b1; p_if.cmd_op = 2'd2; p_if.cmd_addr = 8'h07;
        p_if.cmd_data = 8'h01; p_if.cmd_mask = 8'h01;
        @(negedge clk);
        p_if.cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!p_busy) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL exhaust_timeout: got busy expected idle"); end
        vectors++;
        if (p_setups !== 3 || p_rsps !== 1) begin
            miscompares++;
            $display("FAIL exhaust_attempts: got %0d attempts %0d rsps expected 3 1", p_setups, p_rsps);
        end
        vectors++;
        if (p_last_err !== 1'b1 || p_last_data !== 8'h10) begin
            miscompares++;
            $display("FAIL exhaust_rsp: got err %b data %h expected 1 10", p_last_err, p_last_data);
        end
    endtask

    task automatic test_fill_reset();
        int n_x, n_r;
        xq.delete(); rq.delete();
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            m_if.cmd_valid = 1'b1; m_if.cmd_op = 2'd0;
            m_if.cmd_addr = 8'(8'h40 + i); m_if.cmd_data = 8'(i); m_if.cmd_mask = 8'h00;
            @(negedge clk);
        end
        vectors++;
        if (level !== 5'd16 || m_if.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got level %0d ready %b expected 16 0", level, m_if.cmd_ready);
        end
        m_if.cmd_addr = 8'hEE;
        repeat (3) @(negedge clk);
        m_if.cmd_valid = 1'b0;
        vectors++;
        if (level !== 5'd16 || m_if.PENABLE !== 1'b1 || m_if.PADDR !== 8'h40) begin
            miscompares++;
            $display("FAIL fill_overflow: got level %0d penable %b addr %h expected 16 1 40",
                     level, m_if.PENABLE, m_if.PADDR);
        end
        n_x = xq.size(); n_r = rq.size();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_if.PSELx, m_if.PENABLE, m_if.PWRITE, m_if.cmd_ready, busy} !== 5'b00010 ||
            level !== 5'd0 || {m_if.PADDR, m_if.PWDATA} !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_outputs: got ctrl %b level %0d addr %h expected 00010 0 0000",
                     {m_if.PSELx, m_if.PENABLE, m_if.PWRITE, m_if.cmd_ready, busy}, level, m_if.PADDR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (xq.size() !== n_x || rq.size() !== n_r || busy !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d xfers %0d rsps busy %b level %0d expected %0d %0d 0 0",
                     xq.size(), rq.size(), busy, level, n_x, n_r);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_poll();
        test_poll_mask0();
        test_reserved_op();
        test_poll_exhaust();
        test_fill_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
